data_bus_responder: RTL and testbench

//  Responder side of the processor data port: decodes DataAddress/we/DataOut from the core and returns read data in the same cycle.

---
 rtl/data_bus_responder.sv | 128 ++++++++++++
 tb/tb_data_bus_responder.sv | 167 ++++++++++++++++
 2 files changed

// File: rtl/data_bus_responder.sv
// Memory-mapped responder for the core data port: word RAM, switch input,
// LED register and a compare/match timer, with a same-cycle combinational read path.
module data_bus_responder #(
  parameter int XLEN      = 32,
  parameter int RAM_WORDS = 256,
  parameter int N_SW      = 16,
  parameter int N_LED     = 16,
  parameter int PRESCALE  = 1
) (
  input  logic            clk_i,
  input  logic            rst_i,
  input  logic [XLEN-1:0] DataAddress_i,
  input  logic [XLEN-1:0] DataWr_i,
  input  logic            we_i,
  output logic [XLEN-1:0] DataRd_o,
  input  logic [N_SW-1:0] sw_i,
  output logic [N_LED-1:0] led_o,
  output logic            irq_o
);

  localparam int AW = $clog2(RAM_WORDS);
  localparam int PW = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
  localparam logic [PW-1:0]   PRESC_MAX = PW'(PRESCALE - 1);
  localparam logic [XLEN-1:0] RAM_BASE  = XLEN'(32'h1000);
  localparam logic [XLEN-1:0] RAM_END   = XLEN'(32'h1000 + 4 * RAM_WORDS);
  localparam logic [XLEN-1:0] A_SW      = XLEN'(32'h2000);
  localparam logic [XLEN-1:0] A_LED     = XLEN'(32'h2004);
  localparam logic [XLEN-1:0] A_CNT     = XLEN'(32'h2008);
  localparam logic [XLEN-1:0] A_CMP     = XLEN'(32'h200C);
  localparam logic [XLEN-1:0] A_CTRL    = XLEN'(32'h2010);

  logic [XLEN-1:0] mem [RAM_WORDS];

  logic [XLEN-1:0]  addr_w;
  logic [XLEN-1:0]  ram_off;
  logic [AW-1:0]    ram_idx;
  logic             ram_sel;
  logic             wr_ram, wr_led, wr_cnt, wr_cmp, wr_ctrl;
  logic             unused_bits;

  logic [N_SW-1:0]  sw_meta_p0;
  logic [N_SW-1:0]  sw_sync_p1;
  logic [N_LED-1:0] led_q;
  logic [XLEN-1:0]  cnt_q;
  logic [XLEN-1:0]  cmp_q;
  logic             en_q;
  logic             flag_q;
  logic [PW-1:0]    presc_q;
  logic             tick;
  logic             match;

  assign addr_w      = {DataAddress_i[XLEN-1:2], 2'b00};
  assign ram_off     = addr_w - RAM_BASE;
  assign ram_idx     = ram_off[AW+1:2];
  assign ram_sel     = (addr_w >= RAM_BASE) && (addr_w < RAM_END);
  assign unused_bits = ^{DataAddress_i[1:0], ram_off[1:0], ram_off[XLEN-1:AW+2]};

  // Writes are suppressed while reset is asserted so a pending store is dropped.
  assign wr_ram  = we_i && !rst_i && ram_sel;
  assign wr_led  = we_i && !rst_i && (addr_w == A_LED);
  assign wr_cnt  = we_i && !rst_i && (addr_w == A_CNT);
  assign wr_cmp  = we_i && !rst_i && (addr_w == A_CMP);
  assign wr_ctrl = we_i && !rst_i && (addr_w == A_CTRL);

  always_ff @(posedge clk_i) begin
    if (wr_ram) mem[ram_idx] <= DataWr_i;
  end

  // Switch synchronizer: p0 may go metastable, p1 is the clean sample.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      sw_meta_p0 <= '0;
      sw_sync_p1 <= '0;
    end else begin
      sw_meta_p0 <= sw_i;
      sw_sync_p1 <= sw_meta_p0;
    end
  end

  assign tick  = en_q && (presc_q == PRESC_MAX);
  assign match = (cnt_q == cmp_q);

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      led_q   <= '0;
      cnt_q   <= '0;
      cmp_q   <= '1;
      en_q    <= 1'b0;
      flag_q  <= 1'b0;
      presc_q <= '0;
    end else begin
      if (wr_led)  led_q <= DataWr_i[N_LED-1:0];
      if (wr_cmp)  cmp_q <= DataWr_i;
      if (wr_ctrl) en_q  <= DataWr_i[0];
      if (en_q)    presc_q <= tick ? '0 : presc_q + 1'b1;
      // A CPU store to CNT overrides the tick's increment or reload.
      if (wr_cnt)
        cnt_q <= DataWr_i;
      else if (tick)
        cnt_q <= match ? '0 : cnt_q + 1'b1;
      // A match in the same cycle wins over the write-one-to-clear.
      if (tick && match)
        flag_q <= 1'b1;
      else if (wr_ctrl && DataWr_i[1])
        flag_q <= 1'b0;
    end
  end

  always_comb begin
    DataRd_o = '0;
    if (ram_sel) begin
      DataRd_o = mem[ram_idx];
    end else begin
      case (addr_w)
        A_SW:    DataRd_o = XLEN'(sw_sync_p1);
        A_LED:   DataRd_o = XLEN'(led_q);
        A_CNT:   DataRd_o = cnt_q;
        A_CMP:   DataRd_o = cmp_q;
        A_CTRL:  DataRd_o = XLEN'({flag_q, en_q});
        default: DataRd_o = '0;
      endcase
    end
  end

  assign led_o = led_q;
  assign irq_o = flag_q;

endmodule

// File: tb/tb_data_bus_responder.sv
// Directed bench for data_bus_responder: RAM, switch sync, LED, timer and reset.
module tb_data_bus_responder;

  logic        clk_i = 1'b0;
  logic        rst_i;
  logic [31:0] DataAddress_i;
  logic [31:0] DataWr_i;
  logic        we_i;
  logic [31:0] DataRd_o;
  logic [15:0] sw_i;
  logic [15:0] led_o;
  logic        irq_o;

  int errors = 0;
  int checks = 0;

  data_bus_responder dut (
    .clk_i        (clk_i),
    .rst_i        (rst_i),
    .DataAddress_i(DataAddress_i),
    .DataWr_i     (DataWr_i),
    .we_i         (we_i),
    .DataRd_o     (DataRd_o),
    .sw_i         (sw_i),
    .led_o        (led_o),
    .irq_o        (irq_o)
  );

  always #5 clk_i = ~clk_i;

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk_i);
    #1;
  endtask

  task automatic wr(input logic [31:0] a, input logic [31:0] d);
    DataAddress_i = a;
    DataWr_i      = d;
    we_i          = 1'b1;
    step();
    we_i          = 1'b0;
  endtask

  task automatic rd(input string tag, input logic [31:0] a, input logic [31:0] exp);
    DataAddress_i = a;
    #1;
    chk(tag, DataRd_o, exp);
  endtask

  initial begin
    rst_i = 1'b1;
    DataAddress_i = '0;
    DataWr_i = '0;
    we_i = 1'b0;
    sw_i = '0;
    repeat (2) @(posedge clk_i);
    #1;
    rst_i = 1'b0;

    chk("rst_led", {16'h0, led_o}, 32'h0);
    chk("rst_irq", {31'h0, irq_o}, 32'h0);
    rd("rst_cnt",  32'h2008, 32'h0);
    rd("rst_cmp",  32'h200C, 32'hFFFF_FFFF);
    rd("rst_ctrl", 32'h2010, 32'h0);
    rd("rst_sw",   32'h2000, 32'h0);

    // RAM
    wr(32'h1000, 32'h1111_1111);
    wr(32'h1004, 32'hDEAD_BEEF);
    rd("ram_1004", 32'h1004, 32'hDEAD_BEEF);
    rd("ram_1000", 32'h1000, 32'h1111_1111);
    wr(32'h13FC, 32'hCAFE_0001);
    rd("ram_last", 32'h13FE, 32'hCAFE_0001);
    rd("past_ram", 32'h1400, 32'h0);

    // Switch synchronizer and LED
    sw_i = 16'h00A5;
    rd("sw_e0", 32'h2000, 32'h0);
    step();
    rd("sw_e1", 32'h2000, 32'h0);
    step();
    rd("sw_e2", 32'h2000, 32'h0000_00A5);
    wr(32'h2004, 32'h0000_003C);
    chk("led_o", {16'h0, led_o}, 32'h0000_003C);
    rd("led_rd", 32'h2004, 32'h0000_003C);
    wr(32'h2000, 32'hFFFF_FFFF);
    rd("sw_ro", 32'h2000, 32'h0000_00A5);

    // Timer match sequence with CMP=3
    wr(32'h200C, 32'h3);
    wr(32'h2010, 32'h1);
    rd("t_cnt0", 32'h2008, 32'h0);
    step();
    rd("t_cnt1", 32'h2008, 32'h1);
    step();
    rd("t_cnt2", 32'h2008, 32'h2);
    step();
    rd("t_cnt3", 32'h2008, 32'h3);
    chk("t_irq_pre", {31'h0, irq_o}, 32'h0);
    step();
    rd("t_cnt_wrap", 32'h2008, 32'h0);
    chk("t_irq_set", {31'h0, irq_o}, 32'h1);
    step();
    rd("t_cnt_after", 32'h2008, 32'h1);
    chk("t_irq_hold", {31'h0, irq_o}, 32'h1);

    // W1C without match clears; on match cycle the set wins
    wr(32'h2010, 32'h3);
    chk("w1c_irq", {31'h0, irq_o}, 32'h0);
    rd("w1c_ctrl", 32'h2010, 32'h1);
    rd("w1c_cnt", 32'h2008, 32'h2);
    step();
    rd("m_cnt3", 32'h2008, 32'h3);
    wr(32'h2010, 32'h3);
    chk("m_irq", {31'h0, irq_o}, 32'h1);
    rd("m_cnt", 32'h2008, 32'h0);
    rd("m_ctrl", 32'h2010, 32'h3);

    // CNT write beats tick; unmapped access
    wr(32'h2008, 32'h100);
    rd("cnt_wr", 32'h2008, 32'h100);
    rd("unm_rd", 32'h3000, 32'h0);
    wr(32'h3000, 32'hFFFF_FFFF);
    chk("unm_led", {16'h0, led_o}, 32'h0000_003C);
    rd("unm_cmp", 32'h200C, 32'h3);
    rd("unm_cnt", 32'h2008, 32'h101);
    rd("unm_ram", 32'h1004, 32'hDEAD_BEEF);

    // Disable, load CNT=5, enable, then reset mid-count with a store pending
    wr(32'h2010, 32'h0);
    rd("dis_cnt", 32'h2008, 32'h102);
    wr(32'h2008, 32'h5);
    step();
    rd("hold_cnt", 32'h2008, 32'h5);
    wr(32'h2010, 32'h1);
    rd("pre_rst_cnt", 32'h2008, 32'h5);
    chk("pre_rst_irq", {31'h0, irq_o}, 32'h1);
    DataAddress_i = 32'h2004;
    DataWr_i      = 32'h0000_00FF;
    we_i          = 1'b1;
    rst_i         = 1'b1;
    step();
    we_i = 1'b0;
    chk("mr_led", {16'h0, led_o}, 32'h0);
    chk("mr_irq", {31'h0, irq_o}, 32'h0);
    rd("mr_cnt",  32'h2008, 32'h0);
    rd("mr_ctrl", 32'h2010, 32'h0);
    rd("mr_cmp",  32'h200C, 32'hFFFF_FFFF);
    rd("mr_sw",   32'h2000, 32'h0);
    rd("mr_ram",  32'h1004, 32'hDEAD_BEEF);
    rst_i = 1'b0;
    step();
    rd("post_cnt", 32'h2008, 32'h0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
